regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Round-robin arbiter that shares the single register-file write port between N writeback requesters (default: ALU, load unit, debug loader).
- Drives the 3:8 register-select decoder (`wr_sel` to its select input, `wr_en` to its enable) and the shared 16-bit write-data bus.
- Supports a bounded lock so one requester can issue back-to-back writes, e.g. a debug register-file preload burst.

Parameters:
- N, 3, number of requesters (2..4); index 0 = ALU, 1 = load unit, 2 = debug.
- LOCK_MAX, 8, max consecutive accepts while locked before forced release (1..15).
- R0_RO, 1, when 1, accepted writes to register 0 are acknowledged but not issued.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-requester write request; held until accepted.
- lock  in  N  per-requester lock hint, sampled with req.
- addr  in  3N  packed destination register index, requester i at [3i+2:3i].
- data  in  16N  packed write data, requester i at [16i+15:16i].
- gnt  out  N  combinational one-hot accept; a transfer occurs at an edge where req[i] & gnt[i].
- wr_en  out  1  registered enable to the 3:8 decoder.
- wr_sel  out  3  registered register index to the decoder select.
- wr_data  out  16  registered write data.
- locked  out  1  high while in LOCK state.

Behaviour:
- Reset (asynchronous, rst_n low):
  - wr_en=0, wr_sel=0, wr_data=0, locked=0.
  - Round-robin pointer ptr=0, state=ARB, lock_cnt=0.
  - gnt forced to 0 while rst_n is low.
- ARB state, winner selection:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ... modulo N.
  - gnt = onehot(winner) if any req is high, else 0.
  - At most one gnt bit is ever high.
- Accept (edge with req[w] & gnt[w]):
  - Next cycle: wr_sel=addr[w], wr_data=data[w].
  - wr_en=1, except wr_en=0 if R0_RO=1 and addr[w]==0.
  - ptr = (w+1) mod N.
  - Latency: accept edge k -> wr_en high from edge k through edge k+1, exactly one cycle per accept.
- No accept at an edge:
  - wr_en=0; wr_sel and wr_data hold their previous values.
  - ptr unchanged.
- ARB -> LOCK: on an accept with lock[w]=1. Owner=w, lock_cnt=1, locked=1.
- LOCK state:
  - gnt[owner]=req[owner]; all other gnt bits are 0 regardless of their req.
  - Each accept by the owner increments lock_cnt.
- LOCK -> ARB on the first of:
  - (a) an owner accept with lock[owner]=0 (that write still issues);
  - (b) req[owner]=0 and lock[owner]=0 at an edge;
  - (c) an accept that brings lock_cnt to LOCK_MAX.
  - On every exit: ptr = owner+1 mod N, lock_cnt=0, locked=0.
  - After a forced exit (c), the owner competes normally; a renewed lock is only honoured when it next wins arbitration.
- Owner idle in LOCK: req[owner]=0 with lock[owner]=1 holds LOCK; lock_cnt does not advance and others are not granted.
- Back-to-back issue: the same requester may be accepted on consecutive edges in ARB only if no other requester is pending (pointer fairness).
- Mid-operation reset: a pending wr_en is cleared immediately (asynchronous), so no partial write is issued after reset.
- N=2: pointer wraps 1 -> 0. Requester indices >= N do not exist.

Test Plan:
- Reset, then req=001 with addr0=3, data0=16'hA5A5 -> gnt=001 that cycle; next cycle wr_en=1, wr_sel=3, wr_data=16'hA5A5; the following cycle wr_en=0.
- req=111 held for 6 cycles from ptr=0 -> accept order 0,1,2,0,1,2; wr_en high on 6 consecutive cycles.
- R0_RO=1, requester 1 writes addr=0, data=16'h1234 -> gnt[1]=1, wr_en stays 0, ptr advances to 2.
- Requester 2 holds lock=1 for 10 writes while req0 is high, LOCK_MAX=8 -> 8 consecutive gnt[2], locked=1 throughout; forced exit, then requester 0 is granted next.
- Locked owner drops req and lock while others wait -> returns to ARB at that edge; locked=0; the next requester after the owner is granted in the following cycle.
- rst_n pulsed low for half a cycle during a wr_en=1 cycle -> wr_en falls immediately, ptr=0, state ARB, locked=0.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the writeback requesters and the register-file
// write arbiter. The master side is the requester group, the slave side is
// the arbiter that owns the single write port.
interface regfile_wr_arbiter_if #(
    parameter int N = 3
);
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [3*N-1:0]  addr;
    logic [16*N-1:0] data;
    logic [N-1:0]    gnt;
    logic            wr_en;
    logic [2:0]      wr_sel;
    logic [15:0]     wr_data;
    logic            locked;

    modport master (
        output req, lock, addr, data,
        input  gnt, wr_en, wr_sel, wr_data, locked
    );

    modport slave (
        input  req, lock, addr, data,
        output gnt, wr_en, wr_sel, wr_data, locked
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N
// writeback requesters (ALU, load unit, debug loader). Drives the 3:8
// select decoder and the 16-bit write bus, and supports a bounded lock so
// one requester can issue a back-to-back burst.
module regfile_wr_arbiter #(
    parameter int N        = 3,
    parameter int LOCK_MAX = 8,
    parameter int R0_RO    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);

    typedef enum logic {ARB, LOCK} state_t;

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [1:0]  owner, owner_nxt;
    logic [3:0]  lock_cnt, cnt_nxt;
    logic [1:0]  win;
    logic [2:0]  scan_full;
    logic        found;
    logic [N-1:0] gnt_int;
    logic [2:0]  win_addr;
    logic [15:0] win_data;
    logic        wr_en_q;
    logic [2:0]  wr_sel_q;
    logic [15:0] wr_data_q;

    // Step an index forward around the ring of existing requesters.
    function automatic logic [1:0] next_idx(input logic [1:0] x);
        if (int'(x) >= N - 1)
            return 2'd0;
        return x + 2'd1;
    endfunction

    // Pick the requester to grant: the lock owner while locked, otherwise
    // the first active request found scanning upward from the pointer.
    always_comb begin
        found     = 1'b0;
        win       = ptr;
        scan_full = 3'd0;
        if (state == LOCK) begin
            win   = owner;
            found = bus.req[owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                scan_full = {1'b0, ptr} + 3'(k);
                if (int'(scan_full) >= N)
                    scan_full = scan_full - 3'(N);
                if (!found && bus.req[scan_full[1:0]]) begin
                    found = 1'b1;
                    win   = scan_full[1:0];
                end
            end
        end
    end

    // One-hot grant, held off entirely while reset is asserted.
    always_comb begin
        gnt_int = '0;
        if (rst_n && found)
            gnt_int[win] = 1'b1;
    end

    // Route the winner's address and data toward the write registers.
    always_comb begin
        win_addr = bus.addr[3*win +: 3];
        win_data = bus.data[16*win +: 16];
    end

    // Next-state logic for arbitration/lock, pointer and lock counter.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = lock_cnt;
        case (state)
            ARB: begin
                if (found) begin
                    ptr_nxt = next_idx(win);
                    if (bus.lock[win] && LOCK_MAX > 1) begin
                        state_nxt = LOCK;
                        owner_nxt = win;
                        cnt_nxt   = 4'd1;
                    end
                end
            end
            LOCK: begin
                if (found) begin
                    ptr_nxt = next_idx(owner);
                    if (!bus.lock[owner] || (lock_cnt + 4'd1 == 4'(LOCK_MAX))) begin
                        state_nxt = ARB;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = lock_cnt + 4'd1;
                    end
                end else if (!bus.req[owner] && !bus.lock[owner]) begin
                    state_nxt = ARB;
                    ptr_nxt   = next_idx(owner);
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            lock_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            lock_cnt <= cnt_nxt;
        end
    end

    // Write-port registers: one enable pulse per accept, register 0 suppressed
    // when read-only, select and data held between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 3'd0;
            wr_data_q <= 16'd0;
        end else if (found) begin
            wr_en_q   <= !((R0_RO != 0) && (win_addr == 3'd0));
            wr_sel_q  <= win_addr;
            wr_data_q <= win_data;
        end else begin
            wr_en_q <= 1'b0;
        end
    end

    assign bus.gnt     = gnt_int;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_sel  = wr_sel_q;
    assign bus.wr_data = wr_data_q;
    assign bus.locked  = (state == LOCK);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, compared against a behavioural model of the arbiter.
module tb_regfile_wr_arbiter;

    localparam int N        = 3;
    localparam int LOCK_MAX = 8;
    localparam int R0_RO    = 1;

    logic clk;
    logic rst_n;

    regfile_wr_arbiter_if #(.N(N)) bus();

    regfile_wr_arbiter #(
        .N(N),
        .LOCK_MAX(LOCK_MAX),
        .R0_RO(R0_RO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_ptr;
    int          m_owner;
    int          m_cnt;
    int          m_acc;
    bit          m_locked;
    logic        m_wr_en;
    logic [2:0]  m_wr_sel;
    logic [15:0] m_wr_data;

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int modelWinner();
        int i;
        if (!rst_n)
            return -1;
        if (m_locked)
            return bus.req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (bus.req[i])
                return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] modelGnt();
        logic [N-1:0] g;
        int w;
        g = '0;
        w = modelWinner();
        if (w >= 0)
            g[w] = 1'b1;
        return g;
    endfunction

    task automatic modelReset();
        m_ptr     = 0;
        m_owner   = 0;
        m_cnt     = 0;
        m_acc     = -1;
        m_locked  = 0;
        m_wr_en   = 1'b0;
        m_wr_sel  = 3'd0;
        m_wr_data = 16'd0;
    endtask

    task automatic modelEdge();
        int w;
        logic [2:0] a;
        w = modelWinner();
        m_acc = w;
        if (w >= 0) begin
            a         = bus.addr[3*w +: 3];
            m_wr_sel  = a;
            m_wr_data = bus.data[16*w +: 16];
            m_wr_en   = !(R0_RO == 1 && a == 3'd0);
            m_ptr     = (w + 1) % N;
            if (!m_locked) begin
                if (bus.lock[w] && LOCK_MAX > 1) begin
                    m_locked = 1;
                    m_owner  = w;
                    m_cnt    = 1;
                end
            end else begin
                m_cnt++;
                if (!bus.lock[w] || m_cnt >= LOCK_MAX) begin
                    m_locked = 0;
                    m_cnt    = 0;
                end
            end
        end else begin
            m_wr_en = 1'b0;
            if (m_locked && !bus.req[m_owner] && !bus.lock[m_owner]) begin
                m_locked = 0;
                m_cnt    = 0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [N-1:0] eg;
        logic         el;
        eg = modelGnt();
        el = m_locked;
        checks++;
        assert (bus.gnt === eg) else begin
            errors++;
            $error("[TB] FAIL %s.gnt obs=%b exp=%b", tag, bus.gnt, eg);
        end
        checks++;
        assert (bus.wr_en === m_wr_en) else begin
            errors++;
            $error("[TB] FAIL %s.wr_en obs=%b exp=%b", tag, bus.wr_en, m_wr_en);
        end
        checks++;
        assert (bus.wr_sel === m_wr_sel) else begin
            errors++;
            $error("[TB] FAIL %s.wr_sel obs=%0d exp=%0d", tag, bus.wr_sel, m_wr_sel);
        end
        checks++;
        assert (bus.wr_data === m_wr_data) else begin
            errors++;
            $error("[TB] FAIL %s.wr_data obs=%h exp=%h", tag, bus.wr_data, m_wr_data);
        end
        checks++;
        assert (bus.locked === el) else begin
            errors++;
            $error("[TB] FAIL %s.locked obs=%b exp=%b", tag, bus.locked, el);
        end
    endtask

    task automatic checkValue(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                                 input logic [3*N-1:0] a, input logic [16*N-1:0] d,
                                 input string tag);
        bus.req  = r;
        bus.lock = l;
        bus.addr = a;
        bus.data = d;
        #1;
        checkOutput({tag, ".pre"});
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput({tag, ".post"});
    endtask

    initial begin
        logic [N-1:0]    r;
        logic [N-1:0]    l;
        logic [3*N-1:0]  a;
        logic [16*N-1:0] d;

        $display("[TB] start");
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.lock = '0;
        bus.addr = '0;
        bus.data = '0;
        modelReset();
        #3;
        bus.req = 3'b111;
        #1;
        checkOutput("reset");
        bus.req = '0;
        #8;
        rst_n = 1'b1;

        // Single write from the ALU
        applyStimulus(3'b001, 3'b000, {3'd0, 3'd0, 3'd3}, {16'h0, 16'h0, 16'hA5A5}, "first");
        checkValue("first.wr_sel_lit", int'(bus.wr_sel), 3);
        checkValue("first.wr_data_lit", int'(bus.wr_data), 16'hA5A5);
        applyStimulus(3'b000, 3'b000, '0, '0, "idle");
        checkValue("idle.wr_en_lit", int'(bus.wr_en), 0);

        // Move the pointer back to 0, then round-robin across all three
        applyStimulus(3'b100, 3'b000, {3'd5, 3'd0, 3'd0}, {16'h5555, 16'h0, 16'h0}, "align");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(3'b111, 3'b000, {3'd7, 3'd6, 3'd1},
                          {16'(16'h2000 + i), 16'(16'h1000 + i), 16'(16'h0100 + i)}, "rr");
        end

        // Write to read-only register 0 from the load unit
        applyStimulus(3'b010, 3'b000, {3'd0, 3'd0, 3'd0}, {16'h0, 16'h1234, 16'h0}, "r0ro");
        checkValue("r0ro.wr_en_lit", int'(bus.wr_en), 0);

        // Debug burst with lock held past LOCK_MAX while the ALU waits
        for (int i = 0; i < 10; i++) begin
            applyStimulus(3'b101, 3'b100, {3'(i % 7 + 1), 3'd0, 3'd2},
                          {16'(16'hD000 + i), 16'h0, 16'h0A0A}, "lock");
        end

        // Owner abandons the lock while others wait
        applyStimulus(3'b001, 3'b000, {3'd0, 3'd0, 3'd4}, {16'h0, 16'h0, 16'h4444}, "drop");
        checkValue("drop.locked_lit", int'(bus.locked), 0);
        bus.req = 3'b011;
        #1;
        checkValue("drop.next_gnt_lit", int'(bus.gnt), 1);
        applyStimulus(3'b011, 3'b000, {3'd0, 3'd6, 3'd4}, {16'h0, 16'h6666, 16'h4444}, "after_drop");

        // Reset pulse in the middle of a write cycle
        applyStimulus(3'b010, 3'b000, {3'd0, 3'd2, 3'd0}, {16'h0, 16'hBEEF, 16'h0}, "prerst");
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst");
        checkValue("midrst.wr_en_lit", int'(bus.wr_en), 0);
        #3;
        rst_n = 1'b1;
        applyStimulus(3'b111, 3'b000, {3'd3, 3'd2, 3'd1}, {16'h3, 16'h2, 16'h1}, "postrst");

        // Randomized traffic with requests held until accepted
        r = '0;
        l = '0;
        a = '0;
        d = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (r[i] && m_acc == i)
                    r[i] = 1'b0;
                if (!r[i] && $urandom_range(0, 2) != 0) begin
                    r[i]          = 1'b1;
                    a[3*i +: 3]   = 3'($urandom_range(0, 7));
                    d[16*i +: 16] = 16'($urandom);
                end
                l[i] = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(r, l, a, d, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
